// File: rtl/mux_pkg.sv
// Shared types and width helpers for the sequential channel selector.
package mux_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ESPERA = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  function automatic int sel_w(input int canales);
    return (canales <= 2) ? 1 : $clog2(canales);
  endfunction

  function automatic int cuenta_w(input int permanencia);
    return (permanencia < 1) ? 1 : $clog2(permanencia + 1);
  endfunction

endpackage

// File: rtl/mux_siguiente_canal.sv
// Wrap-around search for the first set mask bit strictly above the pointer.
module mux_siguiente_canal import mux_pkg::*; #(
  parameter int CANALES = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]   i_Ptr,
  input  logic [CANALES-1:0] i_Mascara,
  output logic [SEL_W-1:0]   o_Siguiente,
  output logic               o_Alguno
);

  int               w_j;
  logic [SEL_W-1:0] w_Idx;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    o_Siguiente = i_Ptr;
    w_j         = 0;
    w_Idx       = '0;
    for (int i = CANALES; i >= 1; i--) begin
      w_j = int'(i_Ptr) + i;
      if (w_j >= CANALES) w_j = w_j - CANALES;
      w_Idx = SEL_W'(w_j);
      if (i_Mascara[w_Idx]) o_Siguiente = w_Idx;
    end
    o_Alguno = |i_Mascara;
  end

endmodule

// File: rtl/mux_secuencial.sv
// Registered N-channel selector with valid/ready output and auto channel scan.
// Define MUX_MASCARA_EN to add the i_Mascara port that restricts the scan.
module mux_secuencial import mux_pkg::*; #(
  parameter  int ANCHO       = 4,
  parameter  int CANALES     = 4,
  parameter  int PERMANENCIA = 2,
  localparam int SEL_W       = sel_w(CANALES)
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic [CANALES*ANCHO-1:0]   i_Datos,
  input  logic [SEL_W-1:0]           i_Sel,
  input  logic                       i_Modo,
  input  logic                       i_Hab,
  input  logic                       i_Listo,
`ifdef MUX_MASCARA_EN
  input  logic [CANALES-1:0]         i_Mascara,
`endif
  output logic [ANCHO-1:0]           o_Salida,
  output logic [SEL_W-1:0]           o_Canal,
  output logic                       o_Valido
);

  localparam int CNT_W = cuenta_w(PERMANENCIA);

  estado_t            r_Estado;
  logic [ANCHO-1:0]   r_Salida;
  logic [SEL_W-1:0]   r_Canal;
  logic               r_Valido;
  logic               r_Modo;
  logic [SEL_W-1:0]   r_Ptr;
  logic [CNT_W-1:0]   r_Cnt;

  logic [ANCHO-1:0]   w_Canales [CANALES];
  logic [CANALES-1:0] w_Mascara;
  logic [SEL_W-1:0]   w_SelMan;
  logic [SEL_W-1:0]   w_SigPtr;
  logic               w_Alguno;
  logic [SEL_W-1:0]   w_PtrAuto;
  logic               w_Transf;
  logic               w_UsarSig;
  logic [SEL_W-1:0]   w_Can;
  logic               w_Ok;
  logic               w_Captura;

  for (genvar g = 0; g < CANALES; g++) begin : g_canal
    assign w_Canales[g] = i_Datos[g*ANCHO +: ANCHO];
  end

`ifdef MUX_MASCARA_EN
  assign w_Mascara = i_Mascara;
`else
  assign w_Mascara = '1;
`endif

  mux_siguiente_canal #(
    .CANALES (CANALES),
    .SEL_W   (SEL_W)
  ) u_siguiente (
    .i_Ptr       (r_Ptr),
    .i_Mascara   (w_Mascara),
    .o_Siguiente (w_SigPtr),
    .o_Alguno    (w_Alguno)
  );

  // An auto sample taken right after an accepted auto sample uses the advanced
  // pointer; every other auto capture starts from the first set bit at/after r_Ptr.
  always_comb begin
    w_SelMan  = (int'(i_Sel) >= CANALES) ? SEL_W'(CANALES - 1) : i_Sel;
    w_PtrAuto = w_Mascara[r_Ptr] ? r_Ptr : w_SigPtr;
    w_Transf  = r_Valido & i_Listo;
    w_UsarSig = (r_Estado == ESPERA) && r_Modo;
    w_Can     = !i_Modo ? w_SelMan : (w_UsarSig ? w_SigPtr : w_PtrAuto);
    w_Ok      = !i_Modo || w_Alguno;
    w_Captura = 1'b0;
    case (r_Estado)
      REPOSO:  w_Captura = i_Hab && w_Ok;
      ESPERA:  w_Captura = w_Transf && i_Hab && w_Ok && (!r_Modo || PERMANENCIA == 0);
      PAUSA:   w_Captura = (r_Cnt == '0) && i_Hab && w_Ok;
      default: w_Captura = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_Estado <= REPOSO;
      r_Salida <= '0;
      r_Canal  <= '0;
      r_Valido <= 1'b0;
      r_Modo   <= 1'b0;
      r_Ptr    <= '0;
      r_Cnt    <= '0;
    end else if (w_Captura) begin
      r_Salida <= w_Canales[w_Can];
      r_Canal  <= w_Can;
      r_Valido <= 1'b1;
      r_Modo   <= i_Modo;
      r_Estado <= ESPERA;
      if (i_Modo)         r_Ptr <= w_Can;
      else if (w_UsarSig) r_Ptr <= w_SigPtr;
    end else begin
      case (r_Estado)
        ESPERA: begin
          if (w_Transf) begin
            r_Valido <= 1'b0;
            if (r_Modo) r_Ptr <= w_SigPtr;
            if (r_Modo && PERMANENCIA != 0) begin
              r_Cnt    <= CNT_W'(PERMANENCIA - 1);
              r_Estado <= PAUSA;
            end else begin
              r_Estado <= REPOSO;
            end
          end
        end
        PAUSA: begin
          if (r_Cnt == '0) r_Estado <= REPOSO;
          else             r_Cnt    <= r_Cnt - CNT_W'(1);
        end
        default: r_Estado <= REPOSO;
      endcase
    end
  end

  assign o_Salida = r_Salida;
  assign o_Canal  = r_Canal;
  assign o_Valido = r_Valido;

endmodule

// File: doc/mux_secuencial.md
# mux_secuencial

Registered, parametrised N-channel data selector with valid/ready output handshake and an automatic channel-scan mode. It extends the fixed 4×4-bit combinational selector to any width and channel count. It holds each selected sample stable until the consumer accepts it. In scan mode it steps through channels on its own with a programmable gap between samples. It sits between parallel sensor/data sources and a single downstream consumer (UART framer, display driver).

## Interface
Parameters:
- ANCHO, 4, bit width of each data channel
- CANALES, 4, number of input channels (≥2; need not be a power of two)
- PERMANENCIA, 2, idle cycles inserted between accepted sample and next sample in auto mode (0 allowed)

Ports:
- i_Clk  in  1  single clock; all logic on rising edge
- i_Rst_n  in  1  reset, synchronous, active-low
- i_Datos  in  CANALES*ANCHO  packed channels; channel k at bits [k*ANCHO +: ANCHO]
- i_Sel  in  SEL_W=max(1,$clog2(CANALES))  manual channel select
- i_Modo  in  1  0 = manual, 1 = auto scan
- i_Hab  in  1  enable sampling
- i_Listo  in  1  consumer ready
- i_Mascara  in  CANALES  scan mask (only with MUX_MASCARA_EN)
- o_Salida  out  ANCHO  registered sample
- o_Canal  out  SEL_W  channel index of o_Salida
- o_Valido  out  1  sample valid

## Operation
- Reset (i_Rst_n=0 at an edge): o_Salida=0, o_Canal=0, o_Valido=0, state REPOSO, scan pointer=0, gap counter=0. Reset applies in any state and drops any held sample.
- "Capture" = on one edge: load o_Salida from the selected channel, load o_Canal, set o_Valido=1. Channel is i_Sel in manual mode and the scan pointer in auto mode. i_Modo is sampled only at capture.
- Out-of-range i_Sel (≥CANALES) selects channel CANALES-1.
- Transfer occurs on an edge where o_Valido=1 and i_Listo=1. o_Salida/o_Canal must not change while o_Valido=1 and i_Listo=0.
- States:
  - REPOSO: o_Valido=0. If i_Hab=1, capture → ESPERA.
  - ESPERA: holding a valid sample. No transfer → stay. Transfer in manual mode with i_Hab=1 → capture again on the same edge (back-to-back), stay ESPERA. Transfer in manual mode with i_Hab=0 → REPOSO. Transfer in auto mode → pointer advances. If PERMANENCIA=0 and i_Hab=1, capture at the new pointer on the same edge. Otherwise load counter with PERMANENCIA-1, clear o_Valido, go to PAUSA.
  - PAUSA: o_Valido=0, counter decrements each cycle. At counter=0: i_Hab=1 → capture → ESPERA; i_Hab=0 → REPOSO.
- Pointer advance: next channel upward, CANALES-1 wraps to 0.
- i_Hab dropping in ESPERA never cancels the held sample; it is delivered first.
- i_Modo changing mid-gap takes effect at the next capture. The pointer is retained.

## Timing
- Latency: i_Hab high in REPOSO at edge k → o_Valido=1 with data after edge k. Data is i_Datos at edge k.
- Manual with i_Listo=1 continuously: one sample per cycle.
- Auto with i_Listo=1: o_Valido low for exactly PERMANENCIA cycles between consecutive samples.
- Counter width: $clog2(PERMANENCIA+1), minimum 1.

## Configuration
- MUX_MASCARA_EN defined: port i_Mascara exists. Auto-mode pointer advance skips channels whose mask bit is 0, searching upward with wrap.
  - Entry into auto capture with the current pointer masked first advances to the next set bit.
  - Mask all zeros: no capture; stay or return to REPOSO with o_Valido=0.
  - Manual mode ignores the mask.
- Not defined: no i_Mascara port; all channels are scanned in order.

## Structure
- Package mux_pkg holds the state enum {REPOSO, ESPERA, PAUSA} and the SEL_W helper function.
- One sub-module: mux_siguiente_canal. It is a combinational wrap-around search for the next set mask bit above the pointer and outputs next index plus an any-set flag. Without the macro it is tied to an all-ones mask.

## Test plan
All scenarios use ANCHO=4, CANALES=4, PERMANENCIA=2, i_Datos = ch3..ch0 = D,C,B,A (16'hDCBA).
- Reset: i_Rst_n=0 for 2 edges with i_Hab=1 → o_Salida=0, o_Canal=0, o_Valido=0.
- Manual: i_Sel=2, i_Hab=1, i_Listo=1 → next cycle o_Valido=1, o_Salida=C, o_Canal=2. i_Sel=1 → following cycle o_Salida=B. i_Sel=3 → D.
- Backpressure: held sample C with i_Listo=0 for 3 cycles while i_Sel→0 and i_Datos changes → o_Salida stays C. i_Listo=1 → next cycle shows the new selection.
- Auto scan: i_Modo=1, i_Listo=1 → samples A,B,C,D,A on o_Canal 0,1,2,3,0, each o_Valido pulse separated by exactly 2 low cycles.
- Mask (MUX_MASCARA_EN): i_Mascara=4'b1010 → channels 1,3,1,3 (B,D,B,D). i_Mascara=0 → o_Valido stays 0.
- Reset mid-ESPERA in auto mode (pointer=2) → all outputs 0 next cycle. After release the first sample comes from channel 0.
